// File: rtl/mc_alu_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM driving the ALU and datapath strobes (Moore outputs).
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcode/funct vectors through TRAP instead of NOP).
module mc_alu_ctrl_fsm #(
    parameter int         STATE_W     = 4,
    parameter logic [1:0] TRAP_PC_SRC = 2'd3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic               ext_op,
    output logic               lui_op,
    output logic [4:0]         alu_conf,
    output logic               sign,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] dbg_state
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BR       = 4'd9,
        S_JMP      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2b;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR  = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b;

    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR  = 5'd3, ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_NOR = 5'd5, ALU_SLL = 5'd6, ALU_SRL = 5'd7, ALU_SRA = 5'd8, ALU_SLT = 5'd9;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t BAD_NEXT = S_TRAP;
`else
    localparam state_t BAD_NEXT = S_IF;
`endif

    state_t     r_state;
    logic [5:0] r_op;
    logic [5:0] r_funct;

    // zero is combined with pc_write_cond in the datapath, not here
    logic w_unused;
    assign w_unused = ^{zero, TRAP_PC_SRC};

    assign dbg_state = STATE_W'(r_state);

    function automatic logic [4:0] funct_alu(input logic [5:0] f);
        case (f)
            F_ADD, F_ADDU: funct_alu = ALU_ADD;
            F_SUB, F_SUBU: funct_alu = ALU_SUB;
            F_AND:         funct_alu = ALU_AND;
            F_OR:          funct_alu = ALU_OR;
            F_XOR:         funct_alu = ALU_XOR;
            F_NOR:         funct_alu = ALU_NOR;
            F_SLT, F_SLTU: funct_alu = ALU_SLT;
            F_SLL:         funct_alu = ALU_SLL;
            F_SRL:         funct_alu = ALU_SRL;
            F_SRA:         funct_alu = ALU_SRA;
            default:       funct_alu = ALU_ADD;
        endcase
    endfunction

    // IR fields are captured on the ID->EX edge so later opcode/funct changes are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IF;
            r_op    <= 6'h00;
            r_funct <= 6'h00;
        end else begin
            case (r_state)
                S_IF: r_state <= S_ID;
                S_ID: begin
                    r_op    <= opcode;
                    r_funct <= funct;
                    case (opcode)
                        OP_RTYPE:                    r_state <= S_EX_R;
                        OP_LW, OP_SW:                r_state <= S_MEM_ADDR;
                        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
                        OP_SLTI, OP_SLTIU, OP_LUI:   r_state <= S_EX_I;
                        OP_BEQ:                      r_state <= S_BR;
                        OP_J, OP_JAL:                r_state <= S_JMP;
                        default:                     r_state <= BAD_NEXT;
                    endcase
                end
                S_EX_R: begin
                    case (r_funct)
                        F_SLL, F_SRL, F_SRA, F_ADD, F_ADDU, F_SUB, F_SUBU,
                        F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: r_state <= S_WB_ALU;
                        F_JR, F_JALR:                             r_state <= S_IF;
                        default:                                  r_state <= BAD_NEXT;
                    endcase
                end
                S_EX_I:     r_state <= S_WB_ALU;
                S_MEM_ADDR: r_state <= (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   r_state <= S_WB_MEM;
                default:    r_state <= S_IF;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        pc_source     = 2'd0;
        ext_op        = 1'b0;
        lui_op        = 1'b0;
        alu_conf      = ALU_ADD;
        sign          = 1'b0;
        illegal_instr = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_IF: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'd1;
                end
                S_ID: begin
                    alu_src_b = 2'd3;
                    ext_op    = 1'b1;
                end
                S_EX_R: begin
                    alu_src_a = 2'd1;
                    alu_conf  = funct_alu(r_funct);
                    sign      = !(r_funct == F_ADDU || r_funct == F_SUBU || r_funct == F_SLTU);
                    case (r_funct)
                        F_SLL, F_SRL, F_SRA: alu_src_a = 2'd2;
                        F_JR: begin
                            pc_source = 2'd3;
                            pc_write  = 1'b1;
                        end
                        F_JALR: begin
                            pc_source  = 2'd3;
                            pc_write   = 1'b1;
                            reg_write  = 1'b1;
                            reg_dst    = 2'd1;
                            mem_to_reg = 2'd2;
                        end
                        default: ;
                    endcase
                end
                S_EX_I: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    ext_op    = !(r_op == OP_ANDI || r_op == OP_ORI);
                    sign      = !(r_op == OP_ADDIU || r_op == OP_SLTIU);
                    case (r_op)
                        OP_ANDI:            alu_conf = ALU_AND;
                        OP_ORI:             alu_conf = ALU_OR;
                        OP_SLTI, OP_SLTIU:  alu_conf = ALU_SLT;
                        // lui: A path forced to zero, B carries imm<<16, OR passes it through
                        OP_LUI: begin
                            alu_conf  = ALU_OR;
                            alu_src_a = 2'd2;
                            lui_op    = 1'b1;
                        end
                        default:            alu_conf = ALU_ADD;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    ext_op    = 1'b1;
                    sign      = 1'b1;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = (r_op == OP_RTYPE) ? 2'd1 : 2'd0;
                end
                S_BR: begin
                    alu_src_a     = 2'd1;
                    alu_conf      = ALU_SUB;
                    sign          = 1'b1;
                    pc_source     = 2'd1;
                    pc_write_cond = 1'b1;
                end
                S_JMP: begin
                    pc_source = 2'd2;
                    pc_write  = 1'b1;
                    if (r_op == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: begin
                    illegal_instr = 1'b1;
                    pc_source     = TRAP_PC_SRC;
                    pc_write      = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_alu_ctrl_fsm.sv
// Directed table-driven bench for mc_alu_ctrl_fsm plus hand sequences for reset and branch corners.
module tb_mc_alu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
    logic       ext_op, lui_op, sign, illegal_instr;
    logic [4:0] alu_conf;
    logic [3:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mc_alu_ctrl_fsm #(.STATE_W(4), .TRAP_PC_SRC(2'd3)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .ext_op(ext_op), .lui_op(lui_op), .alu_conf(alu_conf), .sign(sign),
        .illegal_instr(illegal_instr), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zr;
        logic [2:0] cpi;
        logic [3:0] s2;
        logic [3:0] s3;
        logic [3:0] s4;
        logic [4:0] alu;
        logic       sgn;
        logic [1:0] srca;
        logic       ext;
        logic       lui;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic [1:0] pcs;
        logic       pcw;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                                input int cpi, input int s2, input int s3, input int s4,
                                input int alu, input logic sgn, input int srca, input logic ext,
                                input logic lui, input logic rw, input int rd, input int m2r,
                                input int pcs, input logic pcw);
        vec_t v;
        v.op = op; v.fn = fn; v.zr = zr; v.cpi = 3'(cpi);
        v.s2 = 4'(s2); v.s3 = 4'(s3); v.s4 = 4'(s4);
        v.alu = 5'(alu); v.sgn = sgn; v.srca = 2'(srca); v.ext = ext; v.lui = lui;
        v.rw = rw; v.rd = 2'(rd); v.m2r = 2'(m2r); v.pcs = 2'(pcs); v.pcw = pcw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_to_if();
        int k = 0;
        opcode = 6'h02;
        while (dbg_state != 4'd0 && k < 20) begin
            step();
            k++;
        end
        chk("sync_to_if", 32'(dbg_state), 32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [3:0] es;
        string p;
        v = vt[idx];
        p = $sformatf("v%0d_op%0h_fn%0h", idx, v.op, v.fn);
        opcode = v.op;
        funct  = v.fn;
        zero   = v.zr;
        for (int i = 0; i < int'(v.cpi); i++) begin
            case (i)
                0:       es = 4'd0;
                1:       es = 4'd1;
                2:       es = v.s2;
                3:       es = v.s3;
                default: es = v.s4;
            endcase
            chk({p, "_state"}, 32'(dbg_state), 32'(es));
            chk({p, "_illegal"}, 32'(illegal_instr), 32'(es == 4'd11));
            chk({p, "_ir_write"}, 32'(ir_write), 32'(es == 4'd0));
            chk({p, "_mem_read"}, 32'(mem_read), 32'(es == 4'd0 || es == 4'd5));
            chk({p, "_mem_write"}, 32'(mem_write), 32'(es == 4'd6));
            chk({p, "_i_or_d"}, 32'(i_or_d), 32'(es == 4'd5 || es == 4'd6));
            if (i == 2) begin
                chk({p, "_alu_conf"}, 32'(alu_conf), 32'(v.alu));
                chk({p, "_sign"}, 32'(sign), 32'(v.sgn));
                chk({p, "_src_a"}, 32'(alu_src_a), 32'(v.srca));
                chk({p, "_ext_op"}, 32'(ext_op), 32'(v.ext));
                chk({p, "_lui_op"}, 32'(lui_op), 32'(v.lui));
                opcode = 6'h3f;
                funct  = 6'h3f;
            end
            if (i == int'(v.cpi) - 1) begin
                chk({p, "_reg_write"}, 32'(reg_write), 32'(v.rw));
                chk({p, "_reg_dst"}, 32'(reg_dst), 32'(v.rd));
                chk({p, "_mem_to_reg"}, 32'(mem_to_reg), 32'(v.m2r));
                chk({p, "_pc_source"}, 32'(pc_source), 32'(v.pcs));
                chk({p, "_pc_write"}, 32'(pc_write), 32'(v.pcw));
            end
            step();
        end
        chk({p, "_back_to_if"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout state=%0d", dbg_state);
        $fatal(1, "watchdog");
    end

    initial begin
        //              op     fn    zr cpi s2  s3 s4 alu sg sa ex lu rw rd m2r pcs pcw
        vt[0]  = mk(6'h00, 6'h20, 0, 4, 2,  8, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        vt[1]  = mk(6'h00, 6'h21, 0, 4, 2,  8, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        vt[2]  = mk(6'h00, 6'h22, 0, 4, 2,  8, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        vt[3]  = mk(6'h00, 6'h27, 0, 4, 2,  8, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        vt[4]  = mk(6'h00, 6'h2b, 0, 4, 2,  8, 0, 9, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        vt[5]  = mk(6'h00, 6'h03, 0, 4, 2,  8, 0, 8, 1, 2, 0, 0, 1, 1, 0, 0, 0);
        vt[6]  = mk(6'h00, 6'h00, 0, 4, 2,  8, 0, 6, 1, 2, 0, 0, 1, 1, 0, 0, 0);
        vt[7]  = mk(6'h00, 6'h08, 0, 3, 2,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3, 1);
        vt[8]  = mk(6'h00, 6'h09, 0, 3, 2,  0, 0, 0, 1, 1, 0, 0, 1, 1, 2, 3, 1);
        vt[9]  = mk(6'h23, 6'h00, 0, 5, 4,  5, 7, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0);
        vt[10] = mk(6'h2b, 6'h00, 0, 4, 4,  6, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        vt[11] = mk(6'h0b, 6'h00, 0, 4, 3,  8, 0, 9, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        vt[12] = mk(6'h0c, 6'h00, 0, 4, 3,  8, 0, 2, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        vt[13] = mk(6'h0f, 6'h00, 0, 4, 3,  8, 0, 3, 1, 2, 1, 1, 1, 0, 0, 0, 0);
        vt[14] = mk(6'h04, 6'h00, 1, 3, 9,  0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        vt[15] = mk(6'h02, 6'h00, 0, 3, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        vt[16] = mk(6'h03, 6'h00, 0, 3, 10, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 1);
`ifdef ILLEGAL_TRAP_EN
        vt[17] = mk(6'h3f, 6'h00, 0, 3, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        vt[18] = mk(6'h00, 6'h3f, 0, 4, 2, 11, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3, 1);
`else
        vt[17] = mk(6'h3f, 6'h00, 0, 2, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[18] = mk(6'h00, 6'h3f, 0, 3, 2,  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
`endif

        // reset: state IF, every strobe held low while reset_n is low
        #2 reset_n = 1'b0;
        #2;
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_strobes", 32'({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_instr}), 32'd0);
        chk("rst_selects", 32'({alu_src_b, alu_src_a, pc_source, alu_conf, sign, ext_op, lui_op}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_state", 32'(dbg_state), 32'd0);
        chk("rel_ir_write", 32'(ir_write), 32'd1);
        chk("rel_pc_write", 32'(pc_write), 32'd1);
        chk("rel_src_b", 32'(alu_src_b), 32'd1);
        step();
        chk("rel_to_id", 32'(dbg_state), 32'd1);
        sync_to_if();

        for (int k = 0; k < NV; k++) begin
            run_vec(k);
        end

        // beq not taken: PC must not load unconditionally
        opcode = 6'h04;
        zero   = 1'b0;
        step();
        step();
        chk("beq_nt_state", 32'(dbg_state), 32'd9);
        chk("beq_nt_pc_write", 32'(pc_write), 32'd0);
        chk("beq_nt_cond", 32'(pc_write_cond), 32'd1);
        chk("beq_nt_alu", 32'(alu_conf), 32'd1);
        step();
        chk("beq_nt_done", 32'(dbg_state), 32'd0);

        // reset asserted in the middle of a lw read
        opcode = 6'h23;
        step();
        step();
        step();
        chk("lw_mid_state", 32'(dbg_state), 32'd5);
        chk("lw_mid_read", 32'({mem_read, i_or_d}), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("lw_abort_state", 32'(dbg_state), 32'd0);
        chk("lw_abort_strobes", 32'({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_instr, i_or_d}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("lw_rel_state", 32'(dbg_state), 32'd0);
        chk("lw_rel_ir_write", 32'(ir_write), 32'd1);
        step();
        sync_to_if();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
